// File: rtl/fetch_pc_sequencer_super_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : fetch_pc_sequencer_super_pkg                                |
// | Purpose  : Shared fetch definitions: RISC-V control-flow opcodes, the  |
// |            fetch sequencer state encoding and immediate extraction     |
// |            helpers for JAL (J-type) and conditional branch (B-type).   |
// | Ports    : none (package)                                              |
// | Config   : FETCH_RAS_EN (consumed by fetch_pc_sequencer_super)         |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
package fetch_pc_sequencer_super_pkg;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [0:0] {
    RUN       = 1'b0,
    JALR_WAIT = 1'b1
  } fetch_state_t;

  // J-type offset: imm[20|10:1|11|19:12] in inst[31:12], sign-extended to 32 bits.
  function automatic logic [31:0] imm_j(input logic [31:0] inst);
    return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

  // B-type offset: imm[12|10:5] in inst[31:25], imm[4:1|11] in inst[11:7].
  function automatic logic [31:0] imm_b(input logic [31:0] inst);
    return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_pc_sequencer_super_ras.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : fetch_ras                                                   |
// | Purpose  : Circular return-address stack. A push onto a full stack     |
// |            overwrites the oldest entry; the count saturates at DEPTH.  |
// | Ports    : clk, reset        - clock, synchronous active-high reset    |
// |            i_push/i_push_data - push a return address                  |
// |            i_pop             - pop top entry (ignored when empty)      |
// |            o_top             - current top-of-stack value              |
// |            o_empty           - stack holds no entries                  |
// | Config   : instantiated only when FETCH_RAS_EN is defined              |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module fetch_ras #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_top,
  output logic             o_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    ptr_q, ptr_d;   // next free slot
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    w_top_idx;

  assign w_top_idx = ptr_q - PW'(1);
  assign o_top     = mem_q[w_top_idx];
  assign o_empty   = (cnt_q == '0);

  always_comb begin
    mem_d = mem_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (i_push) begin
      // Pointer wrap makes a full-stack push land on the oldest slot.
      mem_d[ptr_q] = i_push_data;
      ptr_d        = ptr_q + PW'(1);
      if (cnt_q != C_FULL) cnt_d = cnt_q + CW'(1);
    end else if (i_pop && !o_empty) begin
      ptr_d = ptr_q - PW'(1);
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entries are qualified by cnt_q, so the storage itself needs no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
`default_nettype wire

// File: rtl/fetch_pc_sequencer_super.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : fetch_pc_sequencer_super                                    |
// | Purpose  : Five-lane fetch PC sequencer. Finds the first control       |
// |            transfer in the fetched group, masks later lanes and        |
// |            computes the next group PC (JAL/branch target, return-stack |
// |            or predicted JALR target, or sequential +20). Unpredicted   |
// |            JALRs park the sequencer in JALR_WAIT until a redirect.     |
// | Ports    : clk, reset                 - clock, sync active-high reset  |
// |            instruction_0..4           - fetched group                  |
// |            jump_0..4, jalr_0..4       - per-lane transfer flags        |
// |            jalr_prediction_valid/target - JALR target prediction       |
// |            fetch_ready                - downstream accepts the group   |
// |            redirect_valid/redirect_pc - backend redirect               |
// |            current_pc_0..4            - lane PCs                       |
// |            fetch_valid_0..4           - lane validity                  |
// |            jalr_wait_o                - sequencer in JALR_WAIT         |
// | Config   : FETCH_RAS_EN - adds the return-address stack (fetch_ras)    |
// |            Requires size >= 32 (instruction fields are in [31:0]).     |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module fetch_pc_sequencer_super
  import fetch_pc_sequencer_super_pkg::*;
#(
  parameter int              size      = 32,
  parameter logic [size-1:0] RESET_PC  = '0,
  parameter int              RAS_DEPTH = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [size-1:0] instruction_0,
  input  logic [size-1:0] instruction_1,
  input  logic [size-1:0] instruction_2,
  input  logic [size-1:0] instruction_3,
  input  logic [size-1:0] instruction_4,
  input  logic            jump_0,
  input  logic            jump_1,
  input  logic            jump_2,
  input  logic            jump_3,
  input  logic            jump_4,
  input  logic            jalr_0,
  input  logic            jalr_1,
  input  logic            jalr_2,
  input  logic            jalr_3,
  input  logic            jalr_4,
  input  logic            jalr_prediction_valid,
  input  logic [size-1:0] jalr_prediction_target,
  input  logic            fetch_ready,
  input  logic            redirect_valid,
  input  logic [size-1:0] redirect_pc,
  output logic [size-1:0] current_pc_0,
  output logic [size-1:0] current_pc_1,
  output logic [size-1:0] current_pc_2,
  output logic [size-1:0] current_pc_3,
  output logic [size-1:0] current_pc_4,
  output logic            fetch_valid_0,
  output logic            fetch_valid_1,
  output logic            fetch_valid_2,
  output logic            fetch_valid_3,
  output logic            fetch_valid_4,
  output logic            jalr_wait_o
);

  localparam logic [size-1:0] C_GROUP_BYTES = size'(20);

  logic [size-1:0] pc_q, pc_d;
  fetch_state_t    state_q, state_d;

  logic [31:0]     w_instr [5];
  logic [4:0]      w_jump, w_jalr;
  logic [size-1:0] w_lane_pc [5];
  logic [4:0]      w_valid;

  // Terminating-lane decode
  logic [2:0]      w_term_lane;
  logic            w_term_jump;
  logic            w_term_jalr;
  logic [31:0]     w_term_instr;
  logic [size-1:0] w_term_pc;
  logic [31:0]     w_jump_off;
  logic [size-1:0] w_jump_target;
  logic            w_accept;

  logic            w_ras_hit;
  logic [size-1:0] w_ras_top;

  assign w_instr[0] = instruction_0[31:0];
  assign w_instr[1] = instruction_1[31:0];
  assign w_instr[2] = instruction_2[31:0];
  assign w_instr[3] = instruction_3[31:0];
  assign w_instr[4] = instruction_4[31:0];
  assign w_jump     = {jump_4, jump_3, jump_2, jump_1, jump_0};
  assign w_jalr     = {jalr_4, jalr_3, jalr_2, jalr_1, jalr_0};

  // Scan from the top lane down so the lowest flagged lane wins. When no
  // lane transfers, lane index 4 stands in and both term flags stay low.
  always_comb begin
    w_term_lane  = 3'd4;
    w_term_jump  = 1'b0;
    w_term_jalr  = 1'b0;
    w_term_instr = '0;
    for (int k = 4; k >= 0; k--) begin
      if (w_jump[k] || w_jalr[k]) begin
        w_term_lane  = 3'(k);
        w_term_jump  = w_jump[k];
        w_term_jalr  = !w_jump[k];
        w_term_instr = w_instr[k];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 5; k++) begin
      w_lane_pc[k] = pc_q + size'(4 * k);
      w_valid[k]   = (state_q == RUN) && (3'(k) <= w_term_lane);
    end
  end

  assign w_term_pc     = pc_q + size'({w_term_lane, 2'b00});
  assign w_jump_off    = (w_term_instr[6:0] == OPC_JAL) ? imm_j(w_term_instr)
                                                        : imm_b(w_term_instr);
  assign w_jump_target = w_term_pc + size'($signed(w_jump_off));
  assign w_accept      = !redirect_valid && fetch_ready && (state_q == RUN);

`ifdef FETCH_RAS_EN
  logic w_ras_call;
  logic w_ras_ret;
  logic w_ras_empty;
  logic w_ras_push;
  logic w_ras_pop;

  // Calls link through x1/x5; a return is jalr x0, rs1 in {x1, x5}.
  assign w_ras_call = (w_term_instr[6:0] == OPC_JAL) &&
                      ((w_term_instr[11:7] == 5'd1) || (w_term_instr[11:7] == 5'd5));
  assign w_ras_ret  = ((w_term_instr[19:15] == 5'd1) || (w_term_instr[19:15] == 5'd5)) &&
                      (w_term_instr[11:7] == 5'd0);
  assign w_ras_hit  = w_term_jalr && w_ras_ret && !w_ras_empty;
  assign w_ras_push = w_accept && w_term_jump && w_ras_call;
  assign w_ras_pop  = w_accept && w_ras_hit;

  fetch_ras #(
    .WIDTH (size),
    .DEPTH (RAS_DEPTH)
  ) u_fetch_ras (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_ras_push),
    .i_push_data (w_term_pc + size'(4)),
    .i_pop       (w_ras_pop),
    .o_top       (w_ras_top),
    .o_empty     (w_ras_empty)
  );
`else
  assign w_ras_hit = 1'b0;
  assign w_ras_top = '0;
`endif

  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    if (redirect_valid) begin
      pc_d    = redirect_pc;
      state_d = RUN;
    end else if (w_accept) begin
      if (w_term_jump) begin
        pc_d = w_jump_target;
      end else if (w_term_jalr) begin
        if (w_ras_hit) begin
          pc_d = {w_ras_top[size-1:1], 1'b0};
        end else if (jalr_prediction_valid) begin
          pc_d = {jalr_prediction_target[size-1:1], 1'b0};
        end else begin
          state_d = JALR_WAIT;
        end
      end else begin
        pc_d = pc_q + C_GROUP_BYTES;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      state_q <= RUN;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  assign current_pc_0  = w_lane_pc[0];
  assign current_pc_1  = w_lane_pc[1];
  assign current_pc_2  = w_lane_pc[2];
  assign current_pc_3  = w_lane_pc[3];
  assign current_pc_4  = w_lane_pc[4];
  assign fetch_valid_0 = w_valid[0];
  assign fetch_valid_1 = w_valid[1];
  assign fetch_valid_2 = w_valid[2];
  assign fetch_valid_3 = w_valid[3];
  assign fetch_valid_4 = w_valid[4];
  assign jalr_wait_o   = (state_q == JALR_WAIT);

endmodule
`default_nettype wire
